cache_controller: RTL

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller_if.sv | 56 +++++
 rtl/cache_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller_if.sv
// Command, lookup, bus and tag-array signals of the L2 cache controller.
// The controller takes the slave side; the environment takes the master side.
interface cache_controller_if #(
    parameter int I_SIZE = 32,
    parameter int A_SIZE = 8
);
    localparam int WW = $clog2(A_SIZE);

    logic              cmd_valid;
    logic [3:0]        cmd;
    logic [I_SIZE-1:0] addr;
    logic              cmd_ready;

    logic              hit;
    logic [WW-1:0]     hit_way;
    logic [1:0]        hit_state;
    logic [WW-1:0]     victim_way;
    logic [1:0]        victim_state;

    logic [1:0]        snoop_in;
    logic              snoop_cmd_hit;

    logic              bus_done;
    logic [2:0]        bus_op;
    logic              bus_req;

    logic              tag_we;
    logic [WW-1:0]     tag_way;
    logic [1:0]        tag_state;
    logic              lru_we;
    logic [WW-1:0]     lru_way;
    logic              clear_all;

    logic [1:0]        snoop_result;
    logic [2:0]        l2_l1;
    logic              done;
    logic              cmd_err;

    modport slave (
        input  cmd_valid, cmd, addr,
        input  hit, hit_way, hit_state, victim_way, victim_state,
        input  snoop_in, snoop_cmd_hit, bus_done,
        output cmd_ready, bus_op, bus_req,
        output tag_we, tag_way, tag_state, lru_we, lru_way, clear_all,
        output snoop_result, l2_l1, done, cmd_err
    );

    modport master (
        output cmd_valid, cmd, addr,
        output hit, hit_way, hit_state, victim_way, victim_state,
        output snoop_in, snoop_cmd_hit, bus_done,
        input  cmd_ready, bus_op, bus_req,
        input  tag_we, tag_way, tag_state, lru_we, lru_way, clear_all,
        input  snoop_result, l2_l1, done, cmd_err
    );
endinterface

// File: rtl/cache_controller.sv
// MESI L2 cache controller FSM: one trace command at a time, tag/LRU writes in DONE.
// Optional CACHE_STATS_EN adds saturating hit/miss/read/write counters.
module cache_controller #(
    parameter int I_SIZE = 32,
    parameter int A_SIZE = 8
) (
    input  logic clk,
    input  logic rst_n,
    cache_controller_if.slave cif
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] read_count,
    output logic [31:0] write_count
`endif
);
    localparam int WW = $clog2(A_SIZE);

    localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
    localparam logic [1:0] SN_NOHIT = 2'd0, SN_HIT = 2'd1, SN_HITM = 2'd2;
    localparam logic [2:0] B_NONE = 3'd0, B_READ = 3'd1, B_WRITE = 3'd2;
    localparam logic [2:0] B_INV = 3'd3, B_RWIM = 3'd4;
    localparam logic [2:0] L_NONE = 3'd0, L_GET = 3'd1, L_SEND = 3'd2;
    localparam logic [2:0] L_INV = 3'd3, L_EVICT = 3'd4;
    localparam logic [3:0] C_RD = 4'd0, C_WR = 4'd1, C_IRD = 4'd2;
    localparam logic [3:0] C_SINV = 4'd3, C_SRD = 4'd4, C_SRWIM = 4'd6;
    localparam logic [3:0] C_CLR = 4'd8;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, EVICT, FETCH, UPGRADE, SNOOP, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [WW-1:0] way_q, way_d;
    logic [1:0]    new_q, new_d;
    logic          tag_q, tag_d;
    logic          lru_q, lru_d;
    logic [2:0]    l2_q, l2_d;
    logic [1:0]    snp_q, snp_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            way_q   <= '0;
            new_q   <= ST_I;
            tag_q   <= 1'b0;
            lru_q   <= 1'b0;
            l2_q    <= L_NONE;
            snp_q   <= SN_NOHIT;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            way_q   <= way_d;
            new_q   <= new_d;
            tag_q   <= tag_d;
            lru_q   <= lru_d;
            l2_q    <= l2_d;
            snp_q   <= snp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        way_d   = way_q;
        new_d   = new_q;
        tag_d   = tag_q;
        lru_d   = lru_q;
        l2_d    = l2_q;
        snp_d   = snp_q;
        unique case (state_q)
            IDLE: if (cif.cmd_valid) begin
                state_d = LOOKUP;
                cmd_d   = cif.cmd;
                tag_d   = 1'b0;
                lru_d   = 1'b0;
                l2_d    = L_NONE;
                snp_d   = SN_NOHIT;
            end
            LOOKUP: begin
                state_d = DONE;
                unique case (cmd_q)
                    C_RD, C_IRD, C_WR: begin
                        lru_d = 1'b1;
                        new_d = ST_M;
                        if (cif.hit) begin
                            way_d = cif.hit_way;
                            if (cmd_q == C_WR) begin
                                tag_d = 1'b1;
                                if (cif.hit_state == ST_S)
                                    state_d = UPGRADE;
                            end else begin
                                l2_d = L_SEND;
                            end
                        end else begin
                            // Misses always refill the LRU victim.
                            way_d = cif.victim_way;
                            tag_d = 1'b1;
                            if (cif.victim_state == ST_M) begin
                                state_d = EVICT;
                                l2_d    = L_EVICT;
                            end else begin
                                state_d = FETCH;
                            end
                        end
                    end
                    C_SINV: if (cif.snoop_cmd_hit && cif.hit_state == ST_S) begin
                        way_d = cif.hit_way;
                        tag_d = 1'b1;
                        new_d = ST_I;
                        l2_d  = L_INV;
                        snp_d = SN_HIT;
                    end
                    C_SRD, C_SRWIM: if (cif.snoop_cmd_hit) begin
                        way_d = cif.hit_way;
                        tag_d = 1'b1;
                        new_d = (cmd_q == C_SRD) ? ST_S : ST_I;
                        if (cmd_q == C_SRWIM)
                            l2_d = L_INV;
                        if (cif.hit_state == ST_M) begin
                            snp_d   = SN_HITM;
                            state_d = SNOOP;
                        end else begin
                            snp_d = SN_HIT;
                        end
                    end
                    default: ;
                endcase
            end
            EVICT: if (cif.bus_done) state_d = FETCH;
            FETCH: if (cif.bus_done) begin
                state_d = DONE;
                if (cmd_q == C_WR) begin
                    l2_d = L_GET;
                end else begin
                    l2_d  = L_SEND;
                    new_d = (cif.snoop_in == SN_HIT || cif.snoop_in == SN_HITM)
                          ? ST_S : ST_E;
                end
            end
            UPGRADE, SNOOP: if (cif.bus_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic in_done;
    logic legal;

    assign in_done = (state_q == DONE);
    assign legal   = cmd_q inside {[4'd0:4'd6], 4'd8, 4'd9};

    always_comb begin
        cif.bus_op = B_NONE;
        unique case (1'b1)
            state_q == EVICT,
            state_q == SNOOP:   cif.bus_op = B_WRITE;
            state_q == FETCH:   cif.bus_op = (cmd_q == C_WR) ? B_RWIM : B_READ;
            state_q == UPGRADE: cif.bus_op = B_INV;
            default: ;
        endcase
    end

    assign cif.cmd_ready    = (state_q == IDLE);
    assign cif.bus_req      = state_q inside {EVICT, FETCH, UPGRADE, SNOOP};
    assign cif.tag_we       = in_done & tag_q;
    assign cif.tag_way      = cif.tag_we ? way_q : '0;
    assign cif.tag_state    = cif.tag_we ? new_q : ST_I;
    assign cif.lru_we       = in_done & lru_q;
    assign cif.lru_way      = cif.lru_we ? way_q : '0;
    assign cif.clear_all    = (state_q == LOOKUP) && (cmd_q == C_CLR);
    assign cif.snoop_result = snp_q;
    assign cif.l2_l1        = l2_q;
    assign cif.done         = in_done;
    assign cif.cmd_err      = in_done & ~legal;

`ifdef CACHE_STATS_EN
    logic cnt_en;
    assign cnt_en = (state_q == LOOKUP) && cmd_q inside {C_RD, C_WR, C_IRD};

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count   <= '0;
            miss_count  <= '0;
            read_count  <= '0;
            write_count <= '0;
        end else if (cnt_en) begin
            if (cif.hit) hit_count <= sat_inc(hit_count);
            else         miss_count <= sat_inc(miss_count);
            if (cmd_q == C_WR) write_count <= sat_inc(write_count);
            else               read_count <= sat_inc(read_count);
        end
    end
`endif
endmodule
